// File: rtl/move_dma_engine.sv
// move_dma_engine: programmable block-move engine that borrows the memory bus via hold/hlda.
// Latency: 2N+3 cycles from the start edge for N words when hlda answers hold one cycle later.
// Backpressure: hlda gates every memory access; losing hlda re-requests the bus and restarts the current word.
//
// Optional feature: define MOVE_CHECKSUM_EN to enable an XOR checksum of all copied words.
//
// Ports:
//   clk, rst             : system clock, asynchronous active-high reset
//   move_sel, op         : decoder flag and opcode (56 = set count, 57 = set src, 59 = set dst + start)
//   operand              : register value accompanying the move instruction
//   hlda / hold          : CPU bus grant / registered bus request
//   mem_addr, mem_rd,
//   mem_wr, mem_wdata,
//   mem_rdata            : memory bus (mem_rdata is combinational on mem_addr)
//   busy, done, cmd_err  : status; done and cmd_err are one-cycle pulses
//   checksum             : XOR of copied words (0 unless MOVE_CHECKSUM_EN)

module move_dma_engine #(
   parameter int CNT_W     = 16,
   parameter int ADDR_W    = 32,
   parameter int ADDR_STEP = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              move_sel,
   input  logic [5:0]        op,
   input  logic [31:0]       operand,
   input  logic              hlda,
   output logic              hold,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              cmd_err,
   output logic [31:0]       checksum
);

   localparam logic [5:0]        OP_CNT = 6'd56;
   localparam logic [5:0]        OP_SRC = 6'd57;
   localparam logic [5:0]        OP_GO  = 6'd59;
   localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(ADDR_STEP);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_READ,
      S_WRITE,
      S_DONE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] src;
   logic [ADDR_W-1:0] dst;
   logic [31:0]       data;
   logic              hold_q;
   logic              busy_q;
   logic              done_q;
   logic              cmd_err_q;
   logic              is_move_cmd;
   logic              start;

   assign is_move_cmd = move_sel && (op == OP_CNT || op == OP_SRC || op == OP_GO);
   assign start       = (state == S_IDLE) && move_sel && (op == OP_GO);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         src       <= '0;
         dst       <= '0;
         data      <= '0;
         hold_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cmd_err_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         // Any move command outside IDLE is dropped and flagged one cycle later.
         cmd_err_q <= is_move_cmd && (state != S_IDLE);
         case (state)
            S_IDLE: begin
               if (move_sel) begin
                  case (op)
                     OP_CNT: cnt <= operand[CNT_W-1:0];
                     OP_SRC: src <= operand[ADDR_W-1:0];
                     OP_GO: begin
                        dst    <= operand[ADDR_W-1:0];
                        busy_q <= 1'b1;
                        if (cnt == '0) begin
                           // Empty transfer: never touch the bus.
                           state  <= S_DONE;
                           done_q <= 1'b1;
                        end else begin
                           state  <= S_REQ;
                           hold_q <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_REQ: begin
               if (hlda) state <= S_READ;
            end
            S_READ: begin
               if (hlda) begin
                  data  <= mem_rdata;
                  state <= S_WRITE;
               end else begin
                  state <= S_REQ;
               end
            end
            S_WRITE: begin
               if (hlda) begin
                  src <= src + STEP;
                  dst <= dst + STEP;
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     state  <= S_DONE;
                     hold_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     state <= S_READ;
                  end
               end else begin
                  // Bus lost mid-word: src/dst/cnt untouched so the word is re-read.
                  state <= S_REQ;
               end
            end
            S_DONE: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign hold      = hold_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cmd_err   = cmd_err_q;
   assign mem_rd    = (state == S_READ) && hlda;
   assign mem_wr    = (state == S_WRITE) && hlda;
   assign mem_addr  = (state == S_READ)  ? src :
                      (state == S_WRITE) ? dst : '0;
   assign mem_wdata = (state == S_WRITE) ? data : 32'd0;

`ifdef MOVE_CHECKSUM_EN
   logic [31:0] csum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csum <= 32'd0;
      end else if (start) begin
         csum <= 32'd0;
      end else if (state == S_WRITE && hlda) begin
         csum <= csum ^ data;
      end
   end

   assign checksum = csum;
`else
   assign checksum = 32'd0;
`endif

endmodule
